// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if: handshake bundle between the sequencer and its
// surroundings (operand shifter, multiplier datapath, output serializer).
// master drives the requests and status inputs; slave is the sequencer.
interface mult_seq_ctrl_if;
    logic start;       // new-multiply request, rising edge significant
    logic mult_done;   // multiplier product valid (level)
    logic fz;          // output serializer busy flag
    logic in_en;       // serial operand shift enable
    logic mult_start;  // one-cycle multiplier start pulse
    logic sz;          // serializer trigger, rising edge loads and shifts out
    logic busy;        // sequencer not idle
    logic done;        // one-cycle completion pulse
    logic error;       // sticky watchdog flag

    modport master (
        output start, mult_done, fz,
        input  in_en, mult_start, sz, busy, done, error
    );

    modport slave (
        input  start, mult_done, fz,
        output in_en, mult_start, sz, busy, done, error
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: control sequencer for a serial-in multiplier with a
// serial-out result shifter. A start edge shifts in N_IN operand bits,
// pulses the multiplier, waits for its product, kicks the output
// serializer with a single sz rising edge, follows its fz busy flag
// through high and low, then pulses done.
// Optional watchdog: define MULT_SEQ_CTRL_WATCHDOG_EN to bound the
// WAIT_MULT / WAIT_FZ_* dwell times and trap into a sticky ERR state.
module mult_seq_ctrl #(
    parameter int N_IN     = 12,
    parameter int MULT_TMO = 64,
    parameter int OUT_TMO  = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_seq_ctrl_if.slave bus
);

    localparam int CW = 5;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SHIFT_IN  = 4'd1;
    localparam logic [3:0] S_START     = 4'd2;
    localparam logic [3:0] S_WAIT_MULT = 4'd3;
    localparam logic [3:0] S_TRIGGER   = 4'd4;
    localparam logic [3:0] S_WAIT_FZ_HI = 4'd5;
    localparam logic [3:0] S_WAIT_FZ_LO = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
`ifdef MULT_SEQ_CTRL_WATCHDOG_EN
    localparam logic [3:0] S_ERR       = 4'd8;
`endif

    // The counter and dwell widths are fixed, so reject parameters they cannot hold.
    if (N_IN < 1 || N_IN > 31 || MULT_TMO < 1 || MULT_TMO > 127 ||
        OUT_TMO < 1 || OUT_TMO > 127) begin : g_bad_param
        $error("mult_seq_ctrl: parameter out of range");
    end

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          start_q, start_d;
    // Cleared by reset, set once start has been seen low: a start held
    // high across reset must drop before it can count as an edge.
    logic          start_arm_q, start_arm_d;
    logic          in_en_q, in_en_d;
    logic          mult_start_q, mult_start_d;
    logic          sz_q, sz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          start_edge;

    assign start_edge = bus.start & ~start_q & start_arm_q;

`ifdef MULT_SEQ_CTRL_WATCHDOG_EN
    logic [6:0] dwell_q, dwell_d;
    logic       error_q, error_d;
    logic       mult_tmo, out_tmo;

    // Last allowed cycle in the current wait state.
    assign mult_tmo = (dwell_q == 7'(MULT_TMO - 1));
    assign out_tmo  = (dwell_q == 7'(OUT_TMO - 1));

    // Dwell counter restarts on every state change and saturates.
    always_comb begin
        dwell_d = dwell_q;
        if (state_d != state_q)
            dwell_d = '0;
        else if (dwell_q != 7'h7f)
            dwell_d = dwell_q + 7'd1;
        error_d = (state_d == S_ERR);
    end

    // Watchdog state.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_q <= '0;
            error_q <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            error_q <= error_d;
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    // Next-state and bit-counter logic.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        start_d     = bus.start;
        start_arm_d = start_arm_q | ~bus.start;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d   = S_SHIFT_IN;
                    bit_cnt_d = '0;
                end
            end
            S_SHIFT_IN: begin
                if (bit_cnt_q == CW'(N_IN - 1))
                    state_d = S_START;
                else
                    bit_cnt_d = bit_cnt_q + CW'(1);
            end
            S_START: state_d = S_WAIT_MULT;
            S_WAIT_MULT: begin
                if (bus.mult_done)
                    state_d = S_TRIGGER;
`ifdef MULT_SEQ_CTRL_WATCHDOG_EN
                else if (mult_tmo)
                    state_d = S_ERR;
`endif
            end
            S_TRIGGER: state_d = S_WAIT_FZ_HI;
            S_WAIT_FZ_HI: begin
                if (bus.fz)
                    state_d = S_WAIT_FZ_LO;
`ifdef MULT_SEQ_CTRL_WATCHDOG_EN
                else if (out_tmo)
                    state_d = S_ERR;
`endif
            end
            S_WAIT_FZ_LO: begin
                if (!bus.fz)
                    state_d = S_DONE;
`ifdef MULT_SEQ_CTRL_WATCHDOG_EN
                else if (out_tmo)
                    state_d = S_ERR;
`endif
            end
            S_DONE: state_d = S_IDLE;
`ifdef MULT_SEQ_CTRL_WATCHDOG_EN
            S_ERR: state_d = S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they
    // line up with state_q and never glitch.
    always_comb begin
        in_en_d      = (state_d == S_SHIFT_IN);
        mult_start_d = (state_d == S_START);
        sz_d         = (state_d != S_TRIGGER);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    // State, counter, start sampling and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            start_q      <= 1'b0;
            start_arm_q  <= 1'b0;
            in_en_q      <= 1'b0;
            mult_start_q <= 1'b0;
            sz_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            start_q      <= start_d;
            start_arm_q  <= start_arm_d;
            in_en_q      <= in_en_d;
            mult_start_q <= mult_start_d;
            sz_q         <= sz_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.in_en      = in_en_q;
    assign bus.mult_start = mult_start_q;
    assign bus.sz         = sz_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed bench for mult_seq_ctrl (N_IN=12).
// A negedge monitor counts output activity per operation; the main
// process drives start/mult_done/fz and compares against hand-derived
// counts and latencies.
module tb_mult_seq_ctrl;

    logic clk = 1'b0;
    logic reset;

    mult_seq_ctrl_if ifc ();

    mult_seq_ctrl #(.N_IN(12), .MULT_TMO(64), .OUT_TMO(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Activity monitor, sampled on the inactive edge.
    logic mon_clr = 1'b1;
    int c_in_en, c_mst, c_szlo, c_done, c_busy, c_err, run_in, max_run;

    always @(negedge clk) begin
        if (mon_clr) begin
            c_in_en <= 0; c_mst <= 0; c_szlo <= 0; c_done <= 0;
            c_busy  <= 0; c_err <= 0; run_in <= 0; max_run <= 0;
        end else begin
            c_in_en <= c_in_en + int'(ifc.in_en);
            c_mst   <= c_mst + int'(ifc.mult_start);
            c_szlo  <= c_szlo + int'(!ifc.sz);
            c_done  <= c_done + int'(ifc.done);
            c_busy  <= c_busy + int'(ifc.busy);
            c_err   <= c_err + int'(ifc.error);
            run_in  <= ifc.in_en ? run_in + 1 : 0;
            if (ifc.in_en && (run_in + 1 > max_run)) max_run <= run_in + 1;
        end
    end

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    function automatic logic sel(input int k);
        case (k)
            0:       return ifc.mult_start;
            1:       return !ifc.sz;
            2:       return ifc.done;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait for a DUT output; an expired bound shows up as a failed compare.
    task automatic wait_hi(input int k, input string tag);
        int n;
        n = 0;
        while (!sel(k) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sel(k)), 1);
    endtask

    // One full operation. fz is raised in TRIGGER and held 24 cycles, so
    // W_hi = 1 and W_lo = 23. exp_busy is the expected busy-cycle count.
    task automatic do_op(input bit pulse_start, input bit pre_done, input int exp_busy,
                         input string tag);
        clr_mon();
        if (pre_done) ifc.mult_done = 1'b1;
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_hi(0, {tag, "_mst"});
        if (pre_done) begin
            @(negedge clk);
            chk({tag, "_wm_sz"}, 32'(ifc.sz), 1);
            chk({tag, "_wm_busy"}, 32'(ifc.busy), 1);
            @(negedge clk);
            chk({tag, "_trig_sz"}, 32'(ifc.sz), 0);
        end else begin
            if (pulse_start) begin
                @(negedge clk); ifc.start = 1'b1;
                @(negedge clk); ifc.start = 1'b0;
                @(negedge clk);
            end else begin
                repeat (3) @(negedge clk);
            end
            ifc.mult_done = 1'b1;
            wait_hi(1, {tag, "_szlo"});
        end
        ifc.fz = 1'b1;
        repeat (24) @(negedge clk);
        ifc.fz = 1'b0;
        ifc.mult_done = 1'b0;
        wait_hi(2, {tag, "_done"});
        repeat (10) @(negedge clk);
        chk({tag, "_in_en"}, 32'(c_in_en), 12);
        chk({tag, "_in_run"}, 32'(max_run), 12);
        chk({tag, "_mst_n"}, 32'(c_mst), 1);
        chk({tag, "_szlo_n"}, 32'(c_szlo), 1);
        chk({tag, "_done_n"}, 32'(c_done), 1);
        chk({tag, "_busy_n"}, 32'(c_busy), 32'(exp_busy));
        chk({tag, "_err_n"}, 32'(c_err), 0);
        chk({tag, "_idle"}, 32'(ifc.busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        ifc.start = 1'b1;        // held high across reset: must not trigger
        ifc.mult_done = 1'b0;
        ifc.fz = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_en", 32'(ifc.in_en), 0);
        chk("rst_mst", 32'(ifc.mult_start), 0);
        chk("rst_sz", 32'(ifc.sz), 1);
        chk("rst_busy", 32'(ifc.busy), 0);
        chk("rst_done", 32'(ifc.done), 0);
        chk("rst_error", 32'(ifc.error), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_start_busy", 32'(ifc.busy), 0);
        chk("held_start_in_en", 32'(ifc.in_en), 0);
        ifc.start = 1'b0;
        repeat (2) @(negedge clk);

        // Basic op: 12 + 1 + 3 + 1 + 1 + 23 + 1 busy cycles.
        do_op(1'b0, 1'b0, 42, "basic");
        // Start edge during WAIT_MULT is dropped.
        do_op(1'b1, 1'b0, 42, "ign_start");
        // Product already valid: one WAIT_MULT cycle, 12+1+1+1+1+23+1.
        do_op(1'b0, 1'b1, 40, "pre_done");

        // Reset in the middle of SHIFT_IN at count 5.
        clr_mon();
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_in_en", 32'(ifc.in_en), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_in_en", 32'(ifc.in_en), 0);
        chk("midrst_sz", 32'(ifc.sz), 1);
        chk("midrst_busy", 32'(ifc.busy), 0);
        repeat (2) @(negedge clk);
        do_op(1'b0, 1'b0, 42, "after_rst");

`ifdef MULT_SEQ_CTRL_WATCHDOG_EN
        // mult_done never arrives: ERR after 64 WAIT_MULT cycles.
        clr_mon();
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_hi(0, "wd_mst");
        repeat (64) @(negedge clk);
        chk("wd_err_pre", 32'(ifc.error), 0);
        chk("wd_busy_pre", 32'(ifc.busy), 1);
        @(negedge clk);
        chk("wd_err", 32'(ifc.error), 1);
        repeat (10) @(negedge clk);
        chk("wd_err_sticky", 32'(ifc.error), 1);
        chk("wd_busy", 32'(ifc.busy), 1);
        chk("wd_sz", 32'(ifc.sz), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("wd_err_clr", 32'(ifc.error), 0);
        chk("wd_busy_clr", 32'(ifc.busy), 0);
`else
        // fz never rises: sequencer parks in WAIT_FZ_HI indefinitely.
        clr_mon();
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_hi(0, "hang_mst");
        repeat (3) @(negedge clk);
        ifc.mult_done = 1'b1;
        wait_hi(1, "hang_szlo");
        ifc.mult_done = 1'b0;
        repeat (500) @(negedge clk);
        chk("hang_busy", 32'(ifc.busy), 1);
        chk("hang_error", 32'(ifc.error), 0);
        chk("hang_sz", 32'(ifc.sz), 1);
        chk("hang_done_n", 32'(c_done), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("hang_rst_busy", 32'(ifc.busy), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
